// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display controller.
// Provides segment patterns, position (slot) indices and the controller state enum.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

  // All segments off, and the single middle bar used as a minus sign.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Display positions, scanned from SLOT_SIGN down to SLOT_UNITS.
  localparam logic [1:0] SLOT_SIGN  = 2'd3;
  localparam logic [1:0] SLOT_HUND  = 2'd2;
  localparam logic [1:0] SLOT_TENS  = 2'd1;
  localparam logic [1:0] SLOT_UNITS = 2'd0;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Active-low one-cold enable vector for a given slot.
  function automatic logic [3:0] slot_enable_n(input logic [1:0] slot);
    logic [3:0] en_n;
    en_n       = 4'hF;
    en_n[slot] = 1'b0;
    return en_n;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Purpose: combinational hex nibble to active-low 7-segment pattern decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none. Ports: hex_i (nibble), seg_o ({g,f,e,d,c,b,a}, active-low).
module hex_to_7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/scan_prescaler.sv
// Purpose: per-slot cycle counter 0..SCAN_DIV-1 with wrap tick and blanking window flag.
// Latency: slot_tick/pre_tick/in_blank are combinational from the registered count.
// Backpressure: none; count held at 0 while run=0. Ports: clk, rst, run, slot_tick, pre_tick, in_blank.
module scan_prescaler #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic slot_tick,
  output logic pre_tick,
  output logic in_blank
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(SCAN_DIV - 2);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign slot_tick = run && (cnt_q == LAST);
  // One cycle ahead of the wrap, so the controller can register frame-end outputs in step.
  assign pre_tick  = run && (cnt_q == PRE_LAST);
  assign in_blank  = cnt_q < BLANK_LIM;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run || slot_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sign_8bits_to_digits.sv
// Purpose: split a signed 8-bit value into sign flag and BCD hundreds/tens/units of |value|.
// Latency: 0 cycles (pure combinational).
// Backpressure: none. Ports: value_i (two's complement), neg_o, hund_o, tens_o, units_o.
module sign_8bits_to_digits (
  input  logic [7:0] value_i,
  output logic       neg_o,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  logic [7:0] mag;
  logic [7:0] rem;

  assign neg_o = value_i[7];

  // Negating 0x80 in 8 bits yields 0x80, which read unsigned is exactly 128.
  assign mag = value_i[7] ? (~value_i + 8'd1) : value_i;

  assign hund_o  = 4'(mag / 8'd100);
  assign rem     = 8'(mag % 8'd100);
  assign tens_o  = 4'(rem / 8'd10);
  assign units_o = 4'(rem % 8'd10);

endmodule

// File: rtl/sig_7seg_scan_ctrl.sv
// Purpose: scans a signed 8-bit value onto a 4-position multiplexed 7-segment display
//          (sign, hundreds, tens, units) using one shared hex decoder.
// Latency: first lit digit BLANK_CYC+1 cycles after the accepting edge; new values
//          take effect from the sign slot of the frame following the transfer.
// Backpressure: in_ready is high in IDLE and only on the last cycle of each frame in SCAN.
// Ports: clk, rst (sync, active-high), in_valid/in_data/in_ready handshake, blank_lz,
//        seg_out (active-low {g..a}), dig_en_n (active-low, [3]=sign..[0]=units), frame_done.
module sig_7seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       blank_lz,
  output logic [6:0] seg_out,
  output logic [3:0] dig_en_n,
  output logic       frame_done
);

  import disp_pkg::*;

  state_e     state_q, state_d;
  logic [7:0] val_q, val_d;
  logic [1:0] slot_q, slot_d;
  logic       in_ready_q, in_ready_d;
  logic       frame_done_q, frame_done_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] dig_en_n_q, dig_en_n_d;

  logic       xfer;
  logic       slot_tick;
  logic       pre_tick;
  logic       in_blank;

  logic       neg;
  logic [3:0] hund, tens, units;
  logic [3:0] dec_in;
  logic [6:0] dec_seg;
  logic       hund_zero, tens_zero;

  scan_prescaler #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_presc (
    .clk       (clk),
    .rst       (rst),
    .run       (state_q == SCAN),
    .slot_tick (slot_tick),
    .pre_tick  (pre_tick),
    .in_blank  (in_blank)
  );

  sign_8bits_to_digits u_digits (
    .value_i (val_q),
    .neg_o   (neg),
    .hund_o  (hund),
    .tens_o  (tens),
    .units_o (units)
  );

  // The single decoder is steered to whichever numeric digit the current slot shows.
  always_comb begin
    dec_in = units;
    case (slot_q)
      SLOT_HUND: dec_in = hund;
      SLOT_TENS: dec_in = tens;
      default:   dec_in = units;
    endcase
  end

  hex_to_7seg u_dec (
    .hex_i (dec_in),
    .seg_o (dec_seg)
  );

  assign hund_zero = (hund == 4'd0);
  assign tens_zero = (tens == 4'd0);

  // in_ready_q is only ever high in IDLE or on a frame-end cycle, so a transfer
  // can never land mid-frame.
  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d      = state_q;
    val_d        = val_q;
    slot_d       = slot_q;
    in_ready_d   = 1'b0;
    frame_done_d = 1'b0;
    seg_d        = SEG_BLANK;
    dig_en_n_d   = 4'hF;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SCAN;
          val_d   = in_data;
          slot_d  = SLOT_SIGN;
        end else begin
          in_ready_d = 1'b1;
        end
      end

      SCAN: begin
        if (xfer) begin
          val_d = in_data;
        end
        if (slot_tick) begin
          // 2-bit wrap takes the units slot straight back to the sign slot.
          slot_d = slot_q - 2'd1;
        end
        // Next cycle is the last of the frame: announce it in step with the state.
        if ((slot_q == SLOT_UNITS) && pre_tick) begin
          in_ready_d   = 1'b1;
          frame_done_d = 1'b1;
        end
        // Display registers follow the current slot/prescaler by one cycle.
        if (!in_blank) begin
          dig_en_n_d = slot_enable_n(slot_q);
          case (slot_q)
            SLOT_SIGN: seg_d = neg ? SEG_MINUS : SEG_BLANK;
            SLOT_HUND: seg_d = (blank_lz && hund_zero) ? SEG_BLANK : dec_seg;
            SLOT_TENS: seg_d = (blank_lz && hund_zero && tens_zero) ? SEG_BLANK : dec_seg;
            default:   seg_d = dec_seg;
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      val_q        <= 8'h00;
      slot_q       <= SLOT_SIGN;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      dig_en_n_q   <= 4'hF;
    end else begin
      state_q      <= state_d;
      val_q        <= val_d;
      slot_q       <= slot_d;
      in_ready_q   <= in_ready_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dig_en_n_q   <= dig_en_n_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign frame_done = frame_done_q;
  assign seg_out    = seg_q;
  assign dig_en_n   = dig_en_n_q;

endmodule

// File: tb/tb_sig_7seg_scan_ctrl.sv
// Bench for sig_7seg_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1.
// Expected outputs come from a frame-position model: cycles since entering SCAN
// map arithmetically onto slot/prescaler, and digits are computed from the value.
module tb_sig_7seg_scan_ctrl;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int F  = 4 * SD;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       blank_lz;
  logic [6:0] seg_out;
  logic [3:0] dig_en_n;
  logic       frame_done;

  sig_7seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .blank_lz   (blank_lz),
    .seg_out    (seg_out),
    .dig_en_n   (dig_en_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] font [16];

  // Model state
  bit         m_scan     = 0;
  int         m_n        = 0;
  logic [7:0] m_val      = 8'h00;
  bit         m_idle_rdy = 0;
  bit         exp_rdy    = 0;
  bit         exp_fd     = 0;
  logic [3:0] exp_en     = 4'hF;
  logic [6:0] exp_seg    = 7'h7F;

  // Captures from the most recent run_frame
  logic [6:0] g_sign, g_hund, g_tens, g_units;
  logic [3:0] g_seen;
  int         g_first;
  int         g_fd;

  function automatic logic [6:0] seg_for(input logic [7:0] val, input int slot, input bit lz);
    int v, mag, h, t, u;
    v   = $signed(val);
    mag = (v < 0) ? -v : v;
    h   = mag / 100;
    t   = (mag / 10) % 10;
    u   = mag % 10;
    case (slot)
      3:       return (v < 0) ? 7'h3F : 7'h7F;
      2:       return (lz && h == 0) ? 7'h7F : font[h];
      1:       return (lz && h == 0 && t == 0) ? 7'h7F : font[t];
      default: return font[u];
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, return #1 after it.
  task automatic run_cycle(input bit r, input bit v, input logic [7:0] d, input bit lz);
    bit xfer;
    int p, slot;
    rst      = r;
    in_valid = v;
    in_data  = d;
    blank_lz = lz;
    xfer     = v && exp_rdy && !r;
    exp_en   = 4'hF;
    exp_seg  = 7'h7F;
    if (!r && m_scan) begin
      p    = m_n % SD;
      slot = 3 - ((m_n / SD) % 4);
      if (p >= BC) begin
        exp_en[slot] = 1'b0;
        exp_seg      = seg_for(m_val, slot, lz);
      end
    end
    if (r) begin
      m_scan     = 0;
      m_val      = 8'h00;
      m_idle_rdy = 0;
    end else if (!m_scan) begin
      if (xfer) begin
        m_scan = 1;
        m_n    = 0;
        m_val  = d;
      end else begin
        m_idle_rdy = 1;
      end
    end else begin
      if (xfer) m_val = d;
      m_n++;
    end
    exp_fd  = m_scan && ((m_n % F) == F - 1);
    exp_rdy = m_scan ? exp_fd : m_idle_rdy;
    @(posedge clk);
    #1;
  endtask

  // Hold in_valid with d until the model says a transfer happened.
  task automatic load(input logic [7:0] d, input bit lz);
    int k;
    bit took;
    k = 0;
    do begin
      took = exp_rdy;
      run_cycle(0, 1, d, lz);
      checks++;
      if ({in_ready, frame_done, dig_en_n, seg_out} !== {exp_rdy, exp_fd, exp_en, exp_seg}) begin
        errors++;
        $display("FAIL load rdy/fd/en/seg got %b/%b/%b/%h want %b/%b/%b/%h",
                 in_ready, frame_done, dig_en_n, seg_out, exp_rdy, exp_fd, exp_en, exp_seg);
      end
      k++;
    end while (!took && k < 64);
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL load_timeout got no transfer want transfer within 64 cycles");
    end
  endtask

  // Run 17 cycles right after a transfer and record what each slot showed.
  task automatic run_frame(input bit lz);
    g_seen  = 4'h0;
    g_first = 0;
    g_fd    = 0;
    g_sign  = 7'h7F; g_hund = 7'h7F; g_tens = 7'h7F; g_units = 7'h7F;
    for (int i = 1; i <= 17; i++) begin
      run_cycle(0, 0, 8'h00, lz);
      checks++;
      if ({in_ready, frame_done, dig_en_n, seg_out} !== {exp_rdy, exp_fd, exp_en, exp_seg}) begin
        errors++;
        $display("FAIL frame cyc %0d rdy/fd/en/seg got %b/%b/%b/%h want %b/%b/%b/%h", i,
                 in_ready, frame_done, dig_en_n, seg_out, exp_rdy, exp_fd, exp_en, exp_seg);
      end
      if (frame_done === 1'b1) g_fd++;
      if (i > 1 && dig_en_n !== 4'hF) begin
        if (g_first == 0) g_first = i;
        case (dig_en_n)
          4'b0111: begin g_sign  = seg_out; g_seen[3] = 1'b1; end
          4'b1011: begin g_hund  = seg_out; g_seen[2] = 1'b1; end
          4'b1101: begin g_tens  = seg_out; g_seen[1] = 1'b1; end
          4'b1110: begin g_units = seg_out; g_seen[0] = 1'b1; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic test_reset;
    bit fd_seen;
    run_cycle(1, 0, 8'h00, 0);
    run_cycle(1, 0, 8'h00, 0);
    checks++;
    if ({in_ready, frame_done, dig_en_n, seg_out} !== {1'b0, 1'b0, 4'hF, 7'h7F}) begin
      errors++;
      $display("FAIL reset_vals got %b/%b/%b/%h want 0/0/1111/7f", in_ready, frame_done, dig_en_n, seg_out);
    end
    fd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(0, 0, 8'h00, 0);
      checks++;
      if ({in_ready, frame_done, dig_en_n, seg_out} !== {exp_rdy, exp_fd, exp_en, exp_seg}) begin
        errors++;
        $display("FAIL idle cyc %0d got %b/%b/%b/%h want %b/%b/%b/%h", i,
                 in_ready, frame_done, dig_en_n, seg_out, exp_rdy, exp_fd, exp_en, exp_seg);
      end
      if (frame_done !== 1'b0) fd_seen = 1;
    end
    checks++;
    if (fd_seen || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_state got fd_seen=%0d rdy=%b want fd_seen=0 rdy=1", fd_seen, in_ready);
    end
  endtask

  task automatic test_load_neg;
    load(8'h85, 0);
    run_frame(0);
    checks++;
    if (g_first != BC + 1) begin
      errors++; $display("FAIL first_lit got %0d want %0d", g_first, BC + 1);
    end
    checks++;
    if ({g_sign, g_hund, g_tens, g_units} !== {7'h3F, 7'h79, 7'h24, 7'h30}) begin
      errors++;
      $display("FAIL neg123 got %h %h %h %h want 3f 79 24 30", g_sign, g_hund, g_tens, g_units);
    end
    checks++;
    if (g_seen !== 4'hF || g_fd != 1) begin
      errors++; $display("FAIL neg123_frame got seen=%b fd=%0d want 1111 1", g_seen, g_fd);
    end
  endtask

  task automatic test_lz;
    load(8'h05, 1);
    run_frame(1);
    checks++;
    if ({g_sign, g_hund, g_tens, g_units} !== {7'h7F, 7'h7F, 7'h7F, 7'h12} || g_seen !== 4'hF) begin
      errors++;
      $display("FAIL lz5 got %h %h %h %h seen=%b want 7f 7f 7f 12 seen=1111",
               g_sign, g_hund, g_tens, g_units, g_seen);
    end
    load(8'h00, 1);
    run_frame(1);
    checks++;
    if ({g_sign, g_hund, g_tens, g_units} !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
      errors++;
      $display("FAIL lz0 got %h %h %h %h want 7f 7f 7f 40", g_sign, g_hund, g_tens, g_units);
    end
  endtask

  task automatic test_min;
    load(8'h80, 0);
    run_frame(0);
    checks++;
    if ({g_sign, g_hund, g_tens, g_units} !== {7'h3F, 7'h79, 7'h24, 7'h00}) begin
      errors++;
      $display("FAIL min128 got %h %h %h %h want 3f 79 24 00", g_sign, g_hund, g_tens, g_units);
    end
  endtask

  task automatic test_back_to_back;
    int k, waits;
    bit took;
    k = 0;
    while ((m_n % F) != 6 && k < 64) begin
      run_cycle(0, 0, 8'h00, 0);
      k++;
    end
    waits = 0;
    k     = 0;
    do begin
      took = exp_rdy;
      run_cycle(0, 1, 8'h07, 0);
      checks++;
      if ({in_ready, frame_done, dig_en_n, seg_out} !== {exp_rdy, exp_fd, exp_en, exp_seg}) begin
        errors++;
        $display("FAIL hold got %b/%b/%b/%h want %b/%b/%b/%h",
                 in_ready, frame_done, dig_en_n, seg_out, exp_rdy, exp_fd, exp_en, exp_seg);
      end
      if (!took) waits++;
      k++;
    end while (!took && k < 64);
    checks++;
    if (waits != 9) begin
      errors++; $display("FAIL hold_wait got %0d want 9", waits);
    end
    run_frame(0);
    checks++;
    if ({g_sign, g_hund, g_tens, g_units} !== {7'h7F, 7'h40, 7'h40, 7'h78}) begin
      errors++;
      $display("FAIL hold7 got %h %h %h %h want 7f 40 40 78", g_sign, g_hund, g_tens, g_units);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    k = 0;
    while ((m_n % F) != 9 && k < 64) begin
      run_cycle(0, 0, 8'h00, 0);
      k++;
    end
    // Reset coincides with an offered value: the value must be dropped.
    run_cycle(1, 1, 8'h33, 0);
    checks++;
    if ({in_ready, frame_done, dig_en_n, seg_out} !== {1'b0, 1'b0, 4'hF, 7'h7F}) begin
      errors++;
      $display("FAIL mid_reset got %b/%b/%b/%h want 0/0/1111/7f", in_ready, frame_done, dig_en_n, seg_out);
    end
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 8'h00, 0);
    checks++;
    if ({in_ready, dig_en_n, seg_out} !== {1'b1, 4'hF, 7'h7F}) begin
      errors++;
      $display("FAIL post_reset_idle got %b/%b/%h want 1/1111/7f", in_ready, dig_en_n, seg_out);
    end
    load(8'h00, 0);
    run_frame(0);
    checks++;
    if ({g_sign, g_units} !== {7'h7F, 7'h40} || g_first != BC + 1) begin
      errors++;
      $display("FAIL reload0 got %h %h first=%0d want 7f 40 first=%0d", g_sign, g_units, g_first, BC + 1);
    end
  endtask

  task automatic test_random;
    logic [7:0] v;
    bit lz;
    int gap;
    for (int it = 0; it < 10; it++) begin
      v   = 8'($urandom_range(0, 255));
      lz  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 5);
      for (int i = 0; i < gap; i++) begin
        run_cycle(0, 0, 8'h00, lz);
        checks++;
        if ({in_ready, frame_done, dig_en_n, seg_out} !== {exp_rdy, exp_fd, exp_en, exp_seg}) begin
          errors++;
          $display("FAIL rnd_gap got %b/%b/%b/%h want %b/%b/%b/%h",
                   in_ready, frame_done, dig_en_n, seg_out, exp_rdy, exp_fd, exp_en, exp_seg);
        end
      end
      load(v, lz);
      run_frame(lz);
      checks++;
      if ({g_sign, g_hund, g_tens, g_units} !==
          {seg_for(v, 3, lz), seg_for(v, 2, lz), seg_for(v, 1, lz), seg_for(v, 0, lz)}) begin
        errors++;
        $display("FAIL rnd val=%h lz=%0d got %h %h %h %h want %h %h %h %h", v, lz,
                 g_sign, g_hund, g_tens, g_units,
                 seg_for(v, 3, lz), seg_for(v, 2, lz), seg_for(v, 1, lz), seg_for(v, 0, lz));
      end
    end
  endtask

  initial begin
    font[0]  = 7'h40; font[1]  = 7'h79; font[2]  = 7'h24; font[3]  = 7'h30;
    font[4]  = 7'h19; font[5]  = 7'h12; font[6]  = 7'h02; font[7]  = 7'h78;
    font[8]  = 7'h00; font[9]  = 7'h10; font[10] = 7'h08; font[11] = 7'h03;
    font[12] = 7'h46; font[13] = 7'h21; font[14] = 7'h06; font[15] = 7'h0E;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    blank_lz = 1'b0;
    test_reset;
    test_load_neg;
    test_lz;
    test_min;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sig_7seg_scan_ctrl.md
Name: sig_7seg_scan_ctrl

Overview:
Scan controller that drives a 4-position multiplexed 7-segment display from one signed 8-bit value. Position order is sign, hundreds, tens, units. It accepts new values over a valid/ready handshake, only at frame boundaries, so no frame ever shows a mix of old and new digits. One shared hex_to_7seg decoder instance is time-multiplexed across the three numeric positions. It sits between value producers (counters, ALU results) and the board display pins.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot; legal range >= 2
BLANK_CYC, 1, cycles at the start of each slot with all digits disabled (anti-ghosting); must be < SCAN_DIV

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  producer has a value on in_data
in_data  in  8  two's-complement value to display
in_ready  out  1  controller accepts in_data this cycle
blank_lz  in  1  1 = blank leading zeros; sampled each slot
seg_out  out  7  shared segment bus, active-low, bit order {g,f,e,d,c,b,a}
dig_en_n  out  4  active-low position enables: [3] sign, [2] hundreds, [1] tens, [0] units
frame_done  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE, held value 0, slot index 3, prescaler 0, seg_out 7'h7F, dig_en_n 4'hF, in_ready 0, frame_done 0. A reset mid-frame aborts the frame immediately and discards the held value.
- States:
  - IDLE: display dark; in_ready=1 from the first cycle after reset.
  - SCAN: cycles slot index 3→2→1→0→3 …
- IDLE→SCAN: on transfer (in_valid && in_ready). The held value is registered. Next cycle is SCAN, slot 3, prescaler 0.
- SCAN never returns to IDLE except via rst.
- Prescaler: counts 0..SCAN_DIV-1 within each slot. At SCAN_DIV-1 it wraps to 0 and the slot index decrements, wrapping 0→3.
- Frame end: slot 0 with prescaler SCAN_DIV-1. On that cycle:
  - in_ready=1 and frame_done=1; in_ready is 0 on all other SCAN cycles.
  - A transfer on that cycle updates the held value, effective from slot 3 of the next frame.
  - With no transfer, the old value is redisplayed.
- in_data is never sampled outside in_ready=1. The producer must hold in_valid/in_data until in_ready.
- Outputs are registered; seg_out and dig_en_n change on the same edge.
  - Prescaler < BLANK_CYC: dig_en_n=4'hF, seg_out=7'h7F.
  - Otherwise: dig_en_n has a single 0 at the slot index.
- Digits: magnitude is |value| in 0..128; -128 (0x80) shows 1,2,8.
- Slot 3 (sign): SEG_MINUS (7'b0111111) if value is negative, else SEG_BLANK (7'h7F).
- Slots 2/1/0: the shared decoder output for the hundreds/tens/units BCD digit.
- Leading-zero blanking (blank_lz=1):
  - Hundreds slot blanked if hundreds==0.
  - Tens slot blanked if hundreds==0 and tens==0.
  - Units slot is never blanked.
- Minus placement: always in the sign position, never shifted next to the first digit.
- Latency from IDLE: first lit digit appears BLANK_CYC+1 cycles after the accepting edge.
- Simultaneous reset and transfer: reset wins; the value is not captured.

Decomposition:
- Shared package (disp_pkg): SEG_BLANK, SEG_MINUS, slot index constants (SLOT_SIGN=3, SLOT_HUND=2, SLOT_TENS=1, SLOT_UNITS=0), state enum {IDLE, SCAN}.
- One sub-module: scan_prescaler. Parameterised SCAN_DIV counter; outputs a slot_tick (wrap) pulse and an in_blank flag (count < BLANK_CYC).
- The controller instantiates existing sign_8bits_to_digits on the held value, plus exactly one hex_to_7seg fed by a slot-indexed mux.

Test Plan (SCAN_DIV=4, BLANK_CYC=1):
- Reset release, in_valid=0 for 20 cycles → in_ready=1, dig_en_n=4'hF, seg_out=7'h7F, frame_done never pulses.
- Load 0x85 (-123), blank_lz=0 → slots show, in order:
  - slot 3: MINUS
  - slot 2: "1"
  - slot 1: "2"
  - slot 0: "3"
  - each slot: 1 dark cycle then 3 lit cycles; frame_done every 16 cycles.
- Load 0x05, blank_lz=1 → sign, hundreds and tens slots enabled but seg_out=7'h7F; units "5". Load 0x00 → units "0".
- Load 0x80 → MINUS, "1", "2", "8".
- Hold in_valid=1 with 0x07 from mid-slot 2 → in_ready low until frame-end cycle. Transfer occurs there, and the next frame shows 7 with no mixed digits.
- Assert rst during slot 1 → next cycle all outputs at reset values and state IDLE; a subsequent load of 0x00 displays "0".
